door_controller: RTL and testbench
==================================

Name: door_controller

Overview:
- Door sequencing FSM directly upstream of the `closing` stage.
- Accepts the car's arrival and current floor. Runs the open / dwell / close door cycle.
- Drives `close` and the latched floor into `closing`, which decodes them into the per-floor `closeDoor` vector.
- Drives `doorBusy` to the motion controller so the car is inhibited while the door is not fully closed.

Parameters:
- NUM_FLOORS, 6: width of the one-hot floor vectors.
- OPEN_CYCLES, 4: cycles spent in OPENING. Must be ≥1.
- DWELL_CYCLES, 16: cycles spent in OPEN without a button press. Must be ≥1.
- CLOSE_CYCLES, 4: cycles spent in CLOSING. Must be ≥1.
- CNT_W, 8: timer width. Each *_CYCLES value must be ≤2^CNT_W.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- arrived  in  1  single-cycle pulse from the motion controller: the car has just stopped.
- stopped  in  1  level: the car is stationary at a floor.
- currentFloor  in  NUM_FLOORS  one-hot current floor.
- openBtn  in  1  door-open request, level-sampled.
- closeBtn  in  1  door-close request, level-sampled.
- obstruct  in  1  door-edge sensor. Only used when DOOR_OBSTRUCT_EN is defined.
- close  out  1  to `closing.close`; high exactly while in the CLOSING state.
- doorFloor  out  NUM_FLOORS  latched floor, driven to `closing.currentFloor`.
- doorOpen  out  1  high exactly while in the OPEN state.
- doorBusy  out  1  high in every state except CLOSED.
- doorState  out  2  encoded state, for debug.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: state = CLOSED, timer = 0, doorFloor = 0. Hence close, doorOpen and doorBusy = 0 and doorState = CLOSED. Reset asserted mid-cycle-of-operation aborts at the next edge.
- Moore machine: all outputs decode from registered state and doorFloor only. No combinational input-to-output path.
- Valid floor: currentFloor has exactly one bit set. A request with a zero or multi-hot floor is ignored and the state stays CLOSED.
- States: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3.
- CLOSED:
  - Opens when (arrived | (openBtn & stopped)) & valid floor.
  - On opening: go to OPENING, latch doorFloor ← currentFloor, load timer ← OPEN_CYCLES-1.
- OPENING:
  - Timer == 0 → OPEN, load timer ← DWELL_CYCLES-1.
  - Otherwise decrement the timer.
  - Buttons are ignored.
- OPEN, in priority order:
  - openBtn reloads DWELL_CYCLES-1 (dwell restarts).
  - Else closeBtn → CLOSING, load CLOSE_CYCLES-1.
  - Else timer == 0 → CLOSING, load CLOSE_CYCLES-1.
  - Else decrement the timer.
  - If openBtn and closeBtn are both high, openBtn wins.
- CLOSING, in priority order:
  - openBtn → OPENING, load OPEN_CYCLES-1 (full reopen travel).
  - Else timer == 0 → CLOSED.
  - Else decrement the timer.
- Held across the whole door cycle:
  - doorFloor holds its value from latch until the next latch; changes on currentFloor while busy are ignored.
  - arrived pulses while doorBusy is high are ignored.
- Latency, from an arrived pulse sampled at cycle t:
  - doorBusy = 1 at t+1.
  - doorOpen = 1 at t+1+OPEN_CYCLES.
  - close spans exactly CLOSE_CYCLES cycles.
  - doorBusy falls the cycle after the last CLOSING cycle.
- Timer: unsigned CNT_W bits. It never decrements below 0; a decrement is only issued when the timer is nonzero.

Optional Feature:
- DOOR_OBSTRUCT_EN defined:
  - obstruct in CLOSING behaves as openBtn: go to OPENING.
  - obstruct in OPEN reloads the dwell, with the same priority as openBtn.
- DOOR_OBSTRUCT_EN undefined: the obstruct port exists but is ignored.

Decomposition:
- Shared package `elevator_pkg` holds:
  - NUM_FLOORS = 6.
  - `door_state_t`, a 2-bit enum with CLOSED/OPENING/OPEN/CLOSING at the encodings above.
  - Function `onehot_valid` (exactly-one-bit check).
- Sub-module `door_timer`:
  - Loadable CNT_W down-counter.
  - Ports: load, loadVal, dec, zero.
  - door_controller instantiates it once.

Test Plan (defaults; cycle numbers are the cycles at which state is observed):
- reset, then arrived at cycle 10 with currentFloor 6'b000100 → doorBusy from 11; doorOpen cycles 15–30; close cycles 31–34; CLOSED at 35; doorFloor = 6'b000100 throughout.
- Same start, openBtn pulsed at cycle 20 → dwell restarts; doorOpen through 36; close 37–40.
- Same start, closeBtn at cycle 17 → close = 1 at 18; CLOSED at 22.
- Same start, openBtn at cycle 32 (mid-CLOSING) → OPENING at 33; doorOpen at 37; close deasserted from 33.
- arrived with currentFloor 6'b000000, then 6'b000110 → stays CLOSED; doorBusy = 0; doorFloor unchanged.
- reset asserted at cycle 20 (OPEN) → cycle 21: doorOpen = 0, doorBusy = 0, doorFloor = 0. With DOOR_OBSTRUCT_EN defined, obstruct at cycle 32 → OPENING at 33; without the macro → CLOSED at 35.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, door state encoding and floor-vector helpers.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 6;
  // Widest floor vector the validity helper accepts; narrower vectors are zero-extended.
  localparam int unsigned MAX_FLOORS = 32;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } door_state_t;

  // True when exactly one bit of the vector is set.
  function automatic logic onehot_valid(input logic [MAX_FLOORS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/door_timer.sv
// Loadable down-counter for door phase timing; saturates at zero.
module door_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = loadVal;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/door_controller.sv
// Door open/dwell/close sequencer feeding the closing stage.
// Define DOOR_OBSTRUCT_EN to let the door-edge sensor reopen the door or extend the dwell.
module door_controller
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int unsigned OPEN_CYCLES  = 4,
  parameter int unsigned DWELL_CYCLES = 16,
  parameter int unsigned CLOSE_CYCLES = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arrived,
  input  logic                  stopped,
  input  logic [NUM_FLOORS-1:0] currentFloor,
  input  logic                  openBtn,
  input  logic                  closeBtn,
  input  logic                  obstruct,
  output logic                  close,
  output logic [NUM_FLOORS-1:0] doorFloor,
  output logic                  doorOpen,
  output logic                  doorBusy,
  output logic [1:0]            doorState
);

  localparam logic [CNT_W-1:0] OpenLoad  = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DwellLoad = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CloseLoad = CNT_W'(CLOSE_CYCLES - 1);

  door_state_t           state_q, state_d;
  logic [NUM_FLOORS-1:0] floor_q, floor_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_dec;
  logic             timer_zero;
  logic             floor_ok;
  logic             reopen;

  assign floor_ok = onehot_valid(MAX_FLOORS'(currentFloor));

`ifdef DOOR_OBSTRUCT_EN
  assign reopen = openBtn | obstruct;
`else
  logic unused_obstruct;
  assign unused_obstruct = obstruct;
  assign reopen          = openBtn;
`endif

  door_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .loadVal (timer_val),
    .dec     (timer_dec),
    .zero    (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    timer_load = 1'b0;
    timer_val  = '0;
    timer_dec  = 1'b0;

    unique case (state_q)
      CLOSED: begin
        if ((arrived | (openBtn & stopped)) & floor_ok) begin
          state_d    = OPENING;
          floor_d    = currentFloor;
          timer_load = 1'b1;
          timer_val  = OpenLoad;
        end
      end
      OPENING: begin
        if (timer_zero) begin
          state_d    = OPEN;
          timer_load = 1'b1;
          timer_val  = DwellLoad;
        end else begin
          timer_dec = 1'b1;
        end
      end
      OPEN: begin
        // A reopen request outranks close so a held open button always keeps the door open.
        if (reopen) begin
          timer_load = 1'b1;
          timer_val  = DwellLoad;
        end else if (closeBtn || timer_zero) begin
          state_d    = CLOSING;
          timer_load = 1'b1;
          timer_val  = CloseLoad;
        end else begin
          timer_dec = 1'b1;
        end
      end
      CLOSING: begin
        if (reopen) begin
          state_d    = OPENING;
          timer_load = 1'b1;
          timer_val  = OpenLoad;
        end else if (timer_zero) begin
          state_d = CLOSED;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: state_d = CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLOSED;
      floor_q <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
    end
  end

  assign close     = (state_q == CLOSING);
  assign doorOpen  = (state_q == OPEN);
  assign doorBusy  = (state_q != CLOSED);
  assign doorState = state_q;
  assign doorFloor = floor_q;

endmodule

// File: tb/tb_door_controller.sv
// Scoreboard bench for door_controller: stimulus queues per-cycle expected state, a monitor checks.
module tb_door_controller;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       arrived = 1'b0;
  logic       stopped = 1'b1;
  logic [5:0] currentFloor = '0;
  logic       openBtn = 1'b0;
  logic       closeBtn = 1'b0;
  logic       obstruct = 1'b0;
  logic       close;
  logic [5:0] doorFloor;
  logic       doorOpen;
  logic       doorBusy;
  logic [1:0] doorState;

  door_controller dut (
    .clk          (clk),
    .reset        (reset),
    .arrived      (arrived),
    .stopped      (stopped),
    .currentFloor (currentFloor),
    .openBtn      (openBtn),
    .closeBtn     (closeBtn),
    .obstruct     (obstruct),
    .close        (close),
    .doorFloor    (doorFloor),
    .doorOpen     (doorOpen),
    .doorBusy     (doorBusy),
    .doorState    (doorState)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval after the k-th rising edge since the last test start.
  int cyc = 0;
  bit cyc_clr = 1'b0;
  always @(posedge clk) cyc <= cyc_clr ? 0 : cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] st;
    logic [5:0] fl;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail = 0;

  function automatic void push(int a, int b, logic [1:0] st, logic [5:0] fl);
    for (int i = a; i <= b; i++) q.push_back('{i, st, fl});
  endfunction

  task automatic chk(string nm, int c, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].c < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL missed_check at cycle %0d: got none expected cycle %0d", cyc, q[0].c);
      void'(q.pop_front());
    end else if (q.size() > 0 && q[0].c == cyc) begin
      e = q.pop_front();
      chk("doorState", cyc, 8'(doorState), 8'(e.st));
      chk("doorFloor", cyc, 8'(doorFloor), 8'(e.fl));
      chk("close", cyc, 8'(close), 8'(e.st == CLOSING));
      chk("doorOpen", cyc, 8'(doorOpen), 8'(e.st == OPEN));
      chk("doorBusy", cyc, 8'(doorBusy), 8'(e.st != CLOSED));
    end
  end

  task automatic start_test();
    @(negedge clk);
    reset = 1'b1; cyc_clr = 1'b1;
    arrived = 1'b0; openBtn = 1'b0; closeBtn = 1'b0; obstruct = 1'b0;
    stopped = 1'b1; currentFloor = '0;
    @(negedge clk);
    reset = 1'b0; cyc_clr = 1'b0;
  endtask

  task automatic wait_cyc(int c);
    int guard = 0;
    while (cyc != c && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_cycle: got cycle %0d expected %0d", cyc, c);
    end
  endtask

  task automatic pulse_arrive(int c, logic [5:0] fl);
    wait_cyc(c);
    currentFloor = fl;
    arrived = 1'b1;
    @(negedge clk);
    arrived = 1'b0;
  endtask

  // which: 0 = openBtn, 1 = closeBtn, 2 = obstruct
  task automatic pulse_btn(int c, int which);
    wait_cyc(c);
    if (which == 0) openBtn = 1'b1;
    else if (which == 1) closeBtn = 1'b1;
    else obstruct = 1'b1;
    @(negedge clk);
    openBtn = 1'b0; closeBtn = 1'b0; obstruct = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending checks expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    // Basic cycle; a late arrival with another floor must not disturb the latched floor.
    start_test();
    push(1, 10, CLOSED, 6'b000000);
    push(11, 14, OPENING, 6'b000100);
    push(15, 30, OPEN, 6'b000100);
    push(31, 34, CLOSING, 6'b000100);
    push(35, 37, CLOSED, 6'b000100);
    pulse_arrive(10, 6'b000100);
    pulse_arrive(20, 6'b100000);
    drain();

    // Open button during dwell restarts it.
    start_test();
    push(1, 10, CLOSED, 6'b000000);
    push(11, 14, OPENING, 6'b000100);
    push(15, 36, OPEN, 6'b000100);
    push(37, 40, CLOSING, 6'b000100);
    push(41, 42, CLOSED, 6'b000100);
    pulse_arrive(10, 6'b000100);
    pulse_btn(20, 0);
    drain();

    // Buttons ignored while opening; close button cuts dwell short.
    start_test();
    push(1, 10, CLOSED, 6'b000000);
    push(11, 14, OPENING, 6'b000100);
    push(15, 17, OPEN, 6'b000100);
    push(18, 21, CLOSING, 6'b000100);
    push(22, 23, CLOSED, 6'b000100);
    pulse_arrive(10, 6'b000100);
    pulse_btn(12, 1);
    pulse_btn(13, 0);
    pulse_btn(17, 1);
    drain();

    // Open button mid-closing forces full reopen travel.
    start_test();
    push(1, 10, CLOSED, 6'b000000);
    push(11, 14, OPENING, 6'b000100);
    push(15, 30, OPEN, 6'b000100);
    push(31, 32, CLOSING, 6'b000100);
    push(33, 36, OPENING, 6'b000100);
    push(37, 52, OPEN, 6'b000100);
    push(53, 56, CLOSING, 6'b000100);
    push(57, 58, CLOSED, 6'b000100);
    pulse_arrive(10, 6'b000100);
    pulse_btn(32, 0);
    drain();

    // Zero and multi-hot floors never open the door.
    start_test();
    push(1, 14, CLOSED, 6'b000000);
    pulse_arrive(5, 6'b000000);
    pulse_arrive(8, 6'b000110);
    pulse_btn(11, 0);
    drain();

    // Reset while open aborts at the next edge.
    start_test();
    push(1, 10, CLOSED, 6'b000000);
    push(11, 14, OPENING, 6'b000100);
    push(15, 20, OPEN, 6'b000100);
    push(21, 24, CLOSED, 6'b000000);
    pulse_arrive(10, 6'b000100);
    wait_cyc(20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drain();

    // Open button needs stopped; simultaneous open and close favours open.
    start_test();
    push(1, 5, CLOSED, 6'b000000);
    push(6, 9, OPENING, 6'b000001);
    push(10, 28, OPEN, 6'b000001);
    push(29, 32, CLOSING, 6'b000001);
    push(33, 34, CLOSED, 6'b000001);
    currentFloor = 6'b000001;
    stopped = 1'b0;
    pulse_btn(2, 0);
    stopped = 1'b1;
    pulse_btn(5, 0);
    wait_cyc(12);
    openBtn = 1'b1;
    closeBtn = 1'b1;
    @(negedge clk);
    openBtn = 1'b0;
    closeBtn = 1'b0;
    drain();

    // Obstruction during closing.
    start_test();
    push(1, 10, CLOSED, 6'b000000);
    push(11, 14, OPENING, 6'b000100);
    push(15, 30, OPEN, 6'b000100);
`ifdef DOOR_OBSTRUCT_EN
    push(31, 32, CLOSING, 6'b000100);
    push(33, 36, OPENING, 6'b000100);
    push(37, 52, OPEN, 6'b000100);
    push(53, 56, CLOSING, 6'b000100);
    push(57, 58, CLOSED, 6'b000100);
`else
    push(31, 34, CLOSING, 6'b000100);
    push(35, 36, CLOSED, 6'b000100);
`endif
    pulse_arrive(10, 6'b000100);
    pulse_btn(32, 2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
